// File: rtl/toggle_hs_rx.sv
// toggle_hs_rx: two-phase (toggle) handshake receiver feeding a show-ahead FIFO with valid/ready output.
// Optional `TOGGLE_RX_EVT_CNT_EN adds a saturating 16-bit accepted-word counter (evt_cnt).
module toggle_hs_rx #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int SYNC  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_t,
    input  logic [DW-1:0]            req_data,
    output logic                     ack_t,
    output logic [DW-1:0]            out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
`ifdef TOGGLE_RX_EVT_CNT_EN
    ,
    output logic [15:0]              evt_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);

    logic [SYNC-1:0] sync_q;
    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            req_s, push, pop;

    assign req_s     = sync_q[SYNC-1];
    assign full      = count == DEPTH[AW:0];
    assign out_valid = count != '0;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    // push sees full from before the edge, so a same-edge pop never makes room for a push
    assign push      = (req_s != ack_t) && !full;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
            ack_t  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], req_t};
            if (push) begin
                ack_t  <= ~ack_t;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) mem[wr_ptr] <= req_data;
    end

`ifdef TOGGLE_RX_EVT_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) evt_cnt <= '0;
        else if (push && evt_cnt != 16'hFFFF) evt_cnt <= evt_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_toggle_hs_rx.sv
// tb_toggle_hs_rx: randomized toggle-sender stimulus with a queue scoreboard and an independent output monitor.
module tb_toggle_hs_rx;
    logic       clk = 1'b0;
    logic       rst;
    logic       req_t;
    logic [7:0] req_data;
    logic       ack_t;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       full;
    logic [2:0] count;
`ifdef TOGGLE_RX_EVT_CNT_EN
    logic [15:0] evt_cnt;
`endif

    int         checks = 0;
    int         failures = 0;
    int         sent = 0;
    logic [7:0] sb [$];
    bit         rnd_done;

    toggle_hs_rx #(.DW(8), .DEPTH(4), .SYNC(2)) dut (
        .clk(clk), .rst(rst), .req_t(req_t), .req_data(req_data), .ack_t(ack_t),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .full(full), .count(count)
`ifdef TOGGLE_RX_EVT_CNT_EN
        , .evt_cnt(evt_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted output word must be the oldest word the sender issued.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (!out_valid) check("idle_data_zero", {24'b0, out_data}, 32'h0);
            else if (out_ready) begin
                if (sb.size() == 0) check("unexpected_word", {24'b0, out_data}, 32'hFFFF_FFFF);
                else check("sb_data", {24'b0, out_data}, {24'b0, sb.pop_front()});
            end
        end
    end

    task automatic wait_ack(output int n);
        n = 0;
        while (ack_t !== req_t && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (ack_t !== req_t) check("ack_timeout", {31'b0, ack_t}, {31'b0, req_t});
    endtask

    task automatic send(input logic [7:0] d, input bit chk_lat);
        int n;
        req_data = d;
        req_t    = ~req_t;
        sb.push_back(d);
        sent++;
        wait_ack(n);
        if (chk_lat) check("latency", n, 3);
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drained_valid", {31'b0, out_valid}, 32'h0);
        check("drained_sb", sb.size(), 0);
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0; req_t = 1'b1; req_data = 8'h3C; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", {31'b0, ack_t}, 32'h0);
        check("rst_valid", {31'b0, out_valid}, 32'h0);
        check("rst_count", {29'b0, count}, 32'h0);
        check("rst_data", {24'b0, out_data}, 32'h0);
        check("rst_full", {31'b0, full}, 32'h0);
        // req_t high at release is a pending event
        sb.push_back(8'h3C);
        sent++;
        @(posedge clk); #1;
        rst = 1'b1;
        wait_ack(n);
        check("rel_latency", n, 3);
        check("rel_valid", {31'b0, out_valid}, 32'h1);
        check("rel_data", {24'b0, out_data}, 32'h3C);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("rel_count", {29'b0, count}, 32'h0);

        out_ready = 1'b1;
        send(8'hA5, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("single_count", {29'b0, count}, 32'h0);
        out_ready = 1'b0;

        for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
        check("fill_full", {31'b0, full}, 32'h1);
        check("fill_count", {29'b0, count}, 32'h4);
        req_data = 8'h05;
        req_t    = ~req_t;
        sb.push_back(8'h05);
        sent++;
        repeat (6) @(posedge clk);
        #1;
        check("bp_no_ack", {31'b0, ack_t ^ req_t}, 32'h1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_ack_held", {31'b0, ack_t ^ req_t}, 32'h1);
        check("bp_count3", {29'b0, count}, 32'h3);
        @(posedge clk); #1;
        check("bp_ack_flip", {31'b0, ack_t ^ req_t}, 32'h0);
        check("bp_count4", {29'b0, count}, 32'h4);
        drain();

        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        req_data = 8'h33;
        req_t    = ~req_t;
        sb.push_back(8'h33);
        sent++;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        check("sim_pending", {31'b0, ack_t ^ req_t}, 32'h1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("sim_count", {29'b0, count}, 32'h2);
        check("sim_ack", {31'b0, ack_t ^ req_t}, 32'h0);
        drain();

        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send(8'($urandom), 1'b0);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();
        check("final_count", {29'b0, count}, 32'h0);
`ifdef TOGGLE_RX_EVT_CNT_EN
        check("evt_cnt", {16'b0, evt_cnt}, (sent > 65535) ? 32'hFFFF : sent);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
